bomba_sequenciador: RTL and testbench

//  Top-level display controller for the bomb timer. Owns the HEX and LEDR outputs and decides who drives them.

---
 rtl/bomba_sequenciador.sv | 135 +++++++++++++
 tb/tb_bomba_sequenciador.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bomba_sequenciador.sv
// bomba_sequenciador: display controller for the bomb timer.
// Selects which source drives HEX/LEDR: the countdown timer while armed,
// the explosion animation (stepped through EXPL_STEP by a prescaler),
// a final pattern once the animation is over, or the frozen timer value
// after a defuse. All outputs are registered.
// Optional feature macro: BOMBA_PISCA_FINAL_EN (blinking final pattern).
module bomba_sequenciador #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int STEP_HZ  = 8,
  parameter int N_CICLOS = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        TEMPO_ACABOU,
  input  logic        DESARMAR,
  input  logic [55:0] TIMER_HEX,
  input  logic [55:0] EXPL_HEX,
  input  logic [17:0] EXPL_LEDR,
  output logic        EXPL_STEP,
  output logic [55:0] HEX,
  output logic [17:0] LEDR,
  output logic [1:0]  ESTADO
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW  = (N_CICLOS > 1) ? $clog2(N_CICLOS + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_CICLOS - 1);

  typedef enum logic [1:0] {
    ARMADO     = 2'b00,
    EXPLODINDO = 2'b01,
    FIM        = 2'b10,
    DESARMADO  = 2'b11
  } estado_t;

  estado_t       estado;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic [55:0]   timer_lat;
  logic          presc_wrap;
`ifdef BOMBA_PISCA_FINAL_EN
  logic          fase;
`endif

  assign ESTADO     = estado;
  assign presc_wrap = (presc == PRESC_MAX);

  // Segment pattern shown while the final phase is "lit": everything on.
  function automatic logic [55:0] hex_final(input logic apagado);
    hex_final = apagado ? '1 : '0;
  endfunction

  function automatic logic [17:0] ledr_final(input logic apagado);
    ledr_final = apagado ? '0 : '1;
  endfunction

  // Sequencer: state, prescaler, step counter and registered pin outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado    <= ARMADO;
      HEX       <= '1;
      LEDR      <= '0;
      EXPL_STEP <= 1'b0;
      presc     <= '0;
      cnt       <= '0;
      timer_lat <= '1;
`ifdef BOMBA_PISCA_FINAL_EN
      fase      <= 1'b0;
`endif
    end else begin
      case (estado)
        ARMADO: begin
          HEX       <= TIMER_HEX;
          LEDR      <= '0;
          timer_lat <= TIMER_HEX;
          EXPL_STEP <= 1'b0;
          // Expiry takes priority over a simultaneous defuse request.
          if (TEMPO_ACABOU) begin
            estado <= EXPLODINDO;
            presc  <= '0;
            cnt    <= '0;
          end else if (DESARMAR) begin
            estado <= DESARMADO;
          end
        end

        EXPLODINDO: begin
          HEX  <= EXPL_HEX;
          LEDR <= EXPL_LEDR;
          if (presc_wrap) begin
            // The pulse is registered, so it appears DIV cycles after entry.
            presc     <= '0;
            EXPL_STEP <= 1'b1;
            cnt       <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              estado <= FIM;
`ifdef BOMBA_PISCA_FINAL_EN
              fase   <= 1'b0;
`endif
            end
          end else begin
            presc     <= presc + PW'(1);
            EXPL_STEP <= 1'b0;
          end
        end

        FIM: begin
          EXPL_STEP <= 1'b0;
          presc     <= presc_wrap ? '0 : presc + PW'(1);
`ifdef BOMBA_PISCA_FINAL_EN
          HEX  <= hex_final(fase);
          LEDR <= ledr_final(fase);
          if (presc_wrap) begin
            fase <= ~fase;
          end
`else
          HEX  <= hex_final(1'b0);
          LEDR <= ledr_final(1'b0);
`endif
        end

        default: begin
          // Defused: show the timer value frozen at the moment of defuse.
          EXPL_STEP <= 1'b0;
          HEX       <= timer_lat;
          LEDR      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomba_sequenciador.sv
// Testbench for bomba_sequenciador with DIV=4, N_CICLOS=3.
module tb_bomba_sequenciador;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        TEMPO_ACABOU;
  logic        DESARMAR;
  logic [55:0] TIMER_HEX;
  logic [55:0] EXPL_HEX;
  logic [17:0] EXPL_LEDR;
  logic        EXPL_STEP;
  logic [55:0] HEX;
  logic [17:0] LEDR;
  logic [1:0]  ESTADO;

  bomba_sequenciador #(
    .CLK_HZ  (16),
    .STEP_HZ (4),
    .N_CICLOS(3)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .TEMPO_ACABOU(TEMPO_ACABOU),
    .DESARMAR    (DESARMAR),
    .TIMER_HEX   (TIMER_HEX),
    .EXPL_HEX    (EXPL_HEX),
    .EXPL_LEDR   (EXPL_LEDR),
    .EXPL_STEP   (EXPL_STEP),
    .HEX         (HEX),
    .LEDR        (LEDR),
    .ESTADO      (ESTADO)
  );

  always #5 CLOCK = ~CLOCK;

  localparam logic [55:0] ALL1 = {56{1'b1}};
  localparam logic [55:0] VA = 56'h0123456789ABCD;
  localparam logic [55:0] VB = 56'hFEDCBA98765432;
  localparam logic [55:0] VC = 56'h11223344556677;
  localparam logic [55:0] VD = 56'h0F0F0F0F0F0F0F;
  localparam logic [55:0] VE = 56'h55555555555555;
  localparam logic [55:0] VF = 56'h7F7F7F7F7F7F7F;

  typedef struct {
    logic        rst;
    logic        tempo;
    logic        desarm;
    logic [55:0] thex;
    logic [1:0]  est;
    logic [55:0] hex;
    logic [17:0] ledr;
    logic        step;
  } vec_t;

  vec_t vecs[10];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    logic [55:0] eh;
    logic [17:0] el;
    logic [55:0] fh;
    logic [17:0] fl;
    int pulses;
    int fase;

    RESET = 1'b1; TEMPO_ACABOU = 1'b0; DESARMAR = 1'b0;
    TIMER_HEX = '0; EXPL_HEX = 56'h3C3C3C3C3C3C3C; EXPL_LEDR = 18'h2A5A5;

    //           rst   tempo desarm thex  est    hex   ledr   step
    vecs[0] = '{1'b1, 1'b0, 1'b0, VA, 2'b00, ALL1, 18'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, VA, 2'b00, ALL1, 18'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, VA, 2'b00, VA,   18'h0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, VB, 2'b00, VB,   18'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, VC, 2'b11, VC,   18'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, VD, 2'b11, VC,   18'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, VE, 2'b11, VC,   18'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, VE, 2'b00, ALL1, 18'h0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, VF, 2'b01, VF,   18'h0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, VF, 2'b00, ALL1, 18'h0, 1'b0};

    #1;
    for (int i = 0; i < 10; i++) begin
      RESET = vecs[i].rst; TEMPO_ACABOU = vecs[i].tempo;
      DESARMAR = vecs[i].desarm; TIMER_HEX = vecs[i].thex;
      tick();
      chk($sformatf("vec%0d_estado", i), 64'(ESTADO), 64'(vecs[i].est));
      chk($sformatf("vec%0d_hex", i), 64'(HEX), 64'(vecs[i].hex));
      chk($sformatf("vec%0d_ledr", i), 64'(LEDR), 64'(vecs[i].ledr));
      chk($sformatf("vec%0d_step", i), 64'(EXPL_STEP), 64'(vecs[i].step));
    end

    // Full explosion: pulses after edges t+4, t+8, t+12, then FIM.
    RESET = 1'b1; tick();
    RESET = 1'b0; TIMER_HEX = VA; tick();
    TEMPO_ACABOU = 1'b1; tick();
    chk("expl_entry_estado", 64'(ESTADO), 64'(2'b01));
    chk("expl_entry_step", 64'(EXPL_STEP), 64'(1'b0));
    TEMPO_ACABOU = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      EXPL_HEX = 56'(k) * 56'h01010101010101;
      EXPL_LEDR = 18'(k * 3 + 1);
      DESARMAR = (k == 5);
      TEMPO_ACABOU = (k == 6);
      eh = EXPL_HEX; el = EXPL_LEDR;
      tick();
      chk($sformatf("expl_k%0d_step", k), 64'(EXPL_STEP), 64'((k % 4) == 0));
      chk($sformatf("expl_k%0d_estado", k), 64'(ESTADO), (k == 12) ? 64'd2 : 64'd1);
      chk($sformatf("expl_k%0d_hex", k), 64'(HEX), 64'(eh));
      chk($sformatf("expl_k%0d_ledr", k), 64'(LEDR), 64'(el));
    end
    DESARMAR = 1'b0; TEMPO_ACABOU = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
`ifdef BOMBA_PISCA_FINAL_EN
      fase = ((j - 1) / 4) % 2;
`else
      fase = 0;
`endif
      fh = (fase == 0) ? 56'h0 : ALL1;
      fl = (fase == 0) ? 18'h3FFFF : 18'h0;
      chk($sformatf("fim_j%0d_estado", j), 64'(ESTADO), 64'(2'b10));
      chk($sformatf("fim_j%0d_step", j), 64'(EXPL_STEP), 64'(1'b0));
      chk($sformatf("fim_j%0d_hex", j), 64'(HEX), 64'(fh));
      chk($sformatf("fim_j%0d_ledr", j), 64'(LEDR), 64'(fl));
    end

    // Reset in the middle of an explosion, then a fresh explosion.
    RESET = 1'b1; tick();
    RESET = 1'b0; tick();
    TEMPO_ACABOU = 1'b1; tick();
    TEMPO_ACABOU = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (EXPL_STEP) pulses++;
    end
    chk("mid_pulses_before_reset", 64'(pulses), 64'd1);
    RESET = 1'b1; tick();
    chk("mid_reset_estado", 64'(ESTADO), 64'(2'b00));
    chk("mid_reset_hex", 64'(HEX), 64'(ALL1));
    chk("mid_reset_ledr", 64'(LEDR), 64'd0);
    chk("mid_reset_step", 64'(EXPL_STEP), 64'd0);
    RESET = 1'b0; tick();
    TEMPO_ACABOU = 1'b1; tick();
    TEMPO_ACABOU = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (EXPL_STEP) pulses++;
      if (k == 3) chk("rerun_no_early_pulse", 64'(pulses), 64'd0);
    end
    chk("rerun_pulses", 64'(pulses), 64'd3);
    chk("rerun_estado", 64'(ESTADO), 64'(2'b10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
